// File: rtl/decoder_2x4_stream.sv
// decoder_2x4_stream
//   Streaming 2-to-4 binary-to-one-hot decoder. Incoming 2-bit codes are
//   queued in a 2-entry elastic buffer so that a single cycle of downstream
//   back-pressure does not stall the producer. The head entry is decoded to a
//   one-hot word. A saturating counter tracks how many words were delivered.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous flush of buffer and counter
//   in_code    2-bit code from producer
//   in_valid   in_code is valid
//   in_ready   block can accept in_code this cycle
//   out        one-hot word of the head entry (0000 when empty)
//   out_valid  out holds a decoded word
//   out_ready  consumer accepts out this cycle
//   count      number of words popped, saturating at 2^CNT_W-1
module decoder_2x4_stream #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [1:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [1:0]       r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_head;

  assign in_ready  = (r_occ != 2'd2) && !clear;
  assign out_valid = (r_occ != 2'd0);
  assign count     = r_count;

  // in_ready already excludes clear; pop is masked so a handshake seen
  // during the flush cycle is neither dequeued nor counted.
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready && !clear;
  assign w_head = r_mem[r_rd_ptr];

  // Decoded from the head register only; no path from in_code.
  always_comb begin
    out = '0;
    if (out_valid) begin
      case (w_head)
        2'b00:   out = 4'b0001;
        2'b01:   out = 4'b0010;
        2'b10:   out = 4'b0100;
        default: out = 4'b1000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_code;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        if (r_count != '1) begin
          r_count <= r_count + 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_2x4_stream.sv
// tb_decoder_2x4_stream
//   Directed bench for decoder_2x4_stream. Instance u_dut uses the default
//   counter width; u_sat uses CNT_W=3 to exercise counter saturation.
module tb_decoder_2x4_stream;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [1:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] count;

  logic       s_clear;
  logic [1:0] s_in_code;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [3:0] s_out;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [2:0] s_count;

  int unsigned n_checks;
  int unsigned n_errors;

  decoder_2x4_stream #(.CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  decoder_2x4_stream #(.CNT_W(3)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .clear     (s_clear),
    .in_code   (s_in_code),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .out       (s_out),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .count     (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    clear       = 1'b0;
    in_code     = 2'b00;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    s_clear     = 1'b0;
    s_in_code   = 2'b00;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out",       out,       4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_count",     count,     8'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_ready", in_ready,  1'b1);

    // Streaming 00,01,10,11 with out_ready=1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 2'b00;
    tick();
    check("stream_lat_valid", out_valid, 1'b1);
    check("stream_0", out, 4'b0001);
    in_code = 2'b01;
    tick();
    check("stream_1", out, 4'b0010);
    in_code = 2'b10;
    tick();
    check("stream_2", out, 4'b0100);
    in_code = 2'b11;
    tick();
    check("stream_3", out, 4'b1000);
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 1'b0);
    check("stream_drain_out",   out,       4'b0000);
    check("stream_count",       count,     8'd4);

    // Back-pressure: push 11 then 01 with out_ready=0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'b11;
    tick();
    in_code = 2'b01;
    #1;
    check("bp_ready_occ1", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_ready_full", in_ready, 1'b0);
    check("bp_head",       out,      4'b1000);
    tick();
    check("bp_hold_out",   out,       4'b1000);
    check("bp_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    check("bp_second",       out,      4'b0010);
    check("bp_ready_return", in_ready, 1'b1);
    check("bp_count",        count,    8'd5);

    // Refill to occupancy 2 with count=5, then clear with in_valid/out_ready high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'b10;
    tick();
    check("clr_pre_full", in_ready, 1'b0);
    clear     = 1'b1;
    in_code   = 2'b00;
    out_ready = 1'b1;
    #1;
    check("clr_ready_low", in_ready, 1'b0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_valid", out_valid, 1'b0);
    check("clr_count", count,     8'd0);
    check("clr_out",   out,       4'b0000);
    tick();
    check("clr_not_stored", out_valid, 1'b0);
    check("clr_count_hold", count,     8'd0);

    // Simultaneous push and pop at occupancy 1, head 10
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'b10;
    tick();
    out_ready = 1'b1;
    in_code   = 2'b00;
    #1;
    check("sim_head", out, 4'b0100);
    tick();
    in_valid = 1'b0;
    #1;
    check("sim_next_out",   out,       4'b0001);
    check("sim_next_valid", out_valid, 1'b1);
    check("sim_count",      count,     8'd1);
    tick();
    check("sim_drained", out_valid, 1'b0);
    check("sim_count2",  count,     8'd2);

    // Asynchronous reset mid-stream at occupancy 2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'b01;
    tick();
    in_code = 2'b10;
    tick();
    in_valid = 1'b0;
    #1;
    check("arst_pre_full", in_ready, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out",       out,       4'b0000);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready",  in_ready,  1'b1);
    check("arst_count",     count,     8'd0);
    tick();
    rst = 1'b0;

    // Saturation on the CNT_W=3 instance: 9 pops, count holds at 7
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      s_in_code = 2'(i);
      tick();
      check("sat_onehot", s_out, 4'b0001 << (i % 4));
    end
    s_in_valid = 1'b0;
    tick();
    check("sat_count", s_count,     3'd7);
    check("sat_empty", s_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
